alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 Parameter SHAMT_W, default $clog2(DATA_WIDTH), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream instruction valid.
REQ-006 in_ready  output  1  unit can accept an instruction.
REQ-007 opcode  input  7  instruction opcode.
REQ-008 func7  input  7  instruction func7 field.
REQ-009 func3  input  3  instruction func3 field.
REQ-010 rs1_data  input  DATA_WIDTH  operand A.
REQ-011 rs2_data  input  DATA_WIDTH  operand B for R-type.
REQ-012 imm  input  DATA_WIDTH  sign-extended immediate, operand B for I-type.
REQ-013 rd_in  input  5  destination register index.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  downstream accepts result.
REQ-016 result  output  DATA_WIDTH  ALU result.
REQ-017 rd_out  output  5  destination index of the result.
REQ-018 regwrite  output  1  write-enable for rd_out.
REQ-019 alu_op  output  4  decoded operation code of the result.
REQ-020 illegal  output  1  instruction not decodable.

Function
REQ-021 Decode SHALL use alu_op codes: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1111 invalid.
REQ-022 R-type (opcode 0110011) SHALL decode {func7,func3} as: 0000000/000 ADD, 0100000/000 SUB, 0000000/001 SLL, /010 SLT, /011 SLTU, /100 XOR, /101 SRL, 0100000/101 SRA, 0000000/110 OR, /111 AND; operand B = rs2_data.
REQ-023 I-type (opcode 0010011) SHALL decode func3: 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND (func7 ignored); 001 SLL only with func7 0000000; 101 SRL with func7 0000000, SRA with 0100000; operand B = imm.
REQ-024 Any other opcode/func combination SHALL produce alu_op 1111, illegal 1, regwrite 0, result 0, latency 1.
REQ-025 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH; SLT signed, SLTU unsigned, result 1 or 0 zero-extended.
REQ-026 Shift amount SHALL be operand B[SHAMT_W-1:0]; SRA replicates rs1_data MSB.
REQ-027 regwrite SHALL be 1 for legal instructions with rd_in != 0, else 0.
REQ-028 FSM states: IDLE, EXEC, DONE; IDLE->DONE on accept of non-serial op; IDLE->EXEC on accept of serial shift with shamt>0; EXEC->DONE when shift counter reaches 0; DONE->IDLE on out_ready with no new accept; DONE->DONE/EXEC on out_ready with simultaneous accept.
REQ-029 in_ready SHALL be 1 in IDLE, equal out_ready in DONE, 0 in EXEC and while rst is high.
REQ-030 Accept occurs on in_valid && in_ready; inputs SHALL be captured on that edge only.
REQ-031 Non-serial latency SHALL be 1 cycle: out_valid rises on the edge after accept.
REQ-032 out_valid is 1 exactly in DONE; result, rd_out, regwrite, alu_op, illegal SHALL hold stable while out_valid && !out_ready.
REQ-033 Back-to-back: with out_ready and in_valid held high, non-serial throughput SHALL be one result per cycle.

Reset
REQ-034 On rst high, asynchronously: state IDLE, out_valid 0, result 0, rd_out 0, regwrite 0, alu_op 1111, illegal 0, shift counter 0.
REQ-035 Reset during EXEC or DONE SHALL discard the in-flight instruction; no result is produced after release.
REQ-036 First accept possible on the first rising edge with rst low.

Configuration
REQ-037 Macro ALU_SERIAL_SHIFT_EN defined: SLL/SRL/SRA use a 1-bit-per-cycle shifter in EXEC; latency = shamt+1 cycles; shamt 0 gives latency 1.
REQ-038 Macro ALU_SERIAL_SHIFT_EN undefined: shifts use a barrel shifter, latency 1; EXEC state unreachable.

Verification
REQ-039 R-type ADD rs1=0xFFFFFFFF rs2=0x1 rd=5 -> next cycle out_valid 1, result 0x0, alu_op 0000, regwrite 1, rd_out 5.
REQ-040 I-type SRAI func7=0100000 rs1=0x80000000 imm=4 -> result 0xF8000000, alu_op 0111; with ALU_SERIAL_SHIFT_EN out_valid 5 cycles after accept.
REQ-041 opcode 0110011 func7=0000001 func3=000 -> illegal 1, alu_op 1111, regwrite 0, result 0.
REQ-042 SLT rs1=0xFFFFFFFE rs2=0x1 -> result 1; SLTU same operands -> result 0; rd_in=0 -> regwrite 0.
REQ-043 out_ready low 3 cycles with result pending -> outputs stable, in_ready 0; then 10 back-to-back ADDs with out_ready high -> 10 results on 10 consecutive cycles.
REQ-044 rst asserted mid-EXEC (serial SLL shamt=20) -> out_valid 0 immediately, no result after release, in_ready 1 first cycle after release.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Single-issue integer ALU with valid/ready handshake on both sides and a
// registered result. Define ALU_SERIAL_SHIFT_EN for a 1-bit-per-cycle shifter.
//
// state | meaning
// IDLE  | empty, ready to accept
// EXEC  | serial shift in progress (ALU_SERIAL_SHIFT_EN only)
// DONE  | result held on outputs until out_ready
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [6:0]            func7,
  input  logic [2:0]            func3,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [4:0]            rd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [4:0]            rd_out,
  output logic                  regwrite,
  output logic [3:0]            alu_op,
  output logic                  illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;
  localparam logic [3:0] OP_INV  = 4'b1111;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] F7_STD = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [4:0]              rd_q, rd_d;
  logic                    regwrite_q, regwrite_d;
  logic [3:0]              alu_op_q, alu_op_d;
  logic                    illegal_q, illegal_d;
  logic [SHAMT_W-1:0]      cnt_q, cnt_d;

  logic [3:0]              dec_op;
  logic                    dec_illegal;
  logic [DATA_WIDTH-1:0]   op_b;
  logic [SHAMT_W-1:0]      shamt;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    accept;

  always_comb begin
    dec_op = OP_INV;
    op_b   = rs2_data;
    case (opcode)
      OPC_R: begin
        case ({func7, func3})
          {F7_STD, 3'b000}: dec_op = OP_ADD;
          {F7_ALT, 3'b000}: dec_op = OP_SUB;
          {F7_STD, 3'b001}: dec_op = OP_SLL;
          {F7_STD, 3'b010}: dec_op = OP_SLT;
          {F7_STD, 3'b011}: dec_op = OP_SLTU;
          {F7_STD, 3'b100}: dec_op = OP_XOR;
          {F7_STD, 3'b101}: dec_op = OP_SRL;
          {F7_ALT, 3'b101}: dec_op = OP_SRA;
          {F7_STD, 3'b110}: dec_op = OP_OR;
          {F7_STD, 3'b111}: dec_op = OP_AND;
          default:          dec_op = OP_INV;
        endcase
      end
      OPC_I: begin
        op_b = imm;
        case (func3)
          3'b000: dec_op = OP_ADD;
          3'b010: dec_op = OP_SLT;
          3'b011: dec_op = OP_SLTU;
          3'b100: dec_op = OP_XOR;
          3'b110: dec_op = OP_OR;
          3'b111: dec_op = OP_AND;
          3'b001: dec_op = (func7 == F7_STD) ? OP_SLL : OP_INV;
          3'b101: begin
            if (func7 == F7_STD)      dec_op = OP_SRL;
            else if (func7 == F7_ALT) dec_op = OP_SRA;
            else                      dec_op = OP_INV;
          end
          default: dec_op = OP_INV;
        endcase
      end
      default: dec_op = OP_INV;
    endcase
  end

  assign dec_illegal = (dec_op == OP_INV);
  assign shamt       = op_b[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (dec_op)
      OP_ADD:  alu_res = rs1_data + op_b;
      OP_SUB:  alu_res = rs1_data - op_b;
      OP_SLL:  alu_res = rs1_data << shamt;
      OP_SLT:  alu_res[0] = ($signed(rs1_data) < $signed(op_b));
      OP_SLTU: alu_res[0] = (rs1_data < op_b);
      OP_XOR:  alu_res = rs1_data ^ op_b;
      OP_SRL:  alu_res = rs1_data >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(rs1_data) >>> shamt);
      OP_OR:   alu_res = rs1_data | op_b;
      OP_AND:  alu_res = rs1_data & op_b;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SERIAL_SHIFT_EN
  logic                  is_shift;
  logic [DATA_WIDTH-1:0] step;

  assign is_shift = (dec_op == OP_SLL) || (dec_op == OP_SRL) || (dec_op == OP_SRA);

  always_comb begin
    step = result_q >> 1;
    case (alu_op_q)
      OP_SLL:  step = result_q << 1;
      OP_SRA:  step = {result_q[DATA_WIDTH-1], result_q[DATA_WIDTH-1:1]};
      default: step = result_q >> 1;
    endcase
  end
`endif

  assign in_ready  = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    alu_op_d   = alu_op_q;
    illegal_d  = illegal_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_EXEC: begin
`ifdef ALU_SERIAL_SHIFT_EN
        result_d = step;
        cnt_d    = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) state_d = S_DONE;
`else
        state_d = S_DONE;
`endif
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // accept only happens from IDLE or a draining DONE, so it overrides both
    if (accept) begin
      state_d    = S_DONE;
      rd_d       = rd_in;
      alu_op_d   = dec_op;
      illegal_d  = dec_illegal;
      regwrite_d = !dec_illegal && (rd_in != 5'd0);
      result_d   = dec_illegal ? '0 : alu_res;
`ifdef ALU_SERIAL_SHIFT_EN
      if (is_shift && (shamt != '0)) begin
        state_d  = S_EXEC;
        result_d = rs1_data;
        cnt_d    = shamt;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      result_q   <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      alu_op_q   <= OP_INV;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      alu_op_q   <= alu_op_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  assign result   = result_q;
  assign rd_out   = rd_q;
  assign regwrite = regwrite_q;
  assign alu_op   = alu_op_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: transaction-level model plus directed literal vectors.
module tb_alu_exec_unit;

`ifdef ALU_SERIAL_SHIFT_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [6:0]  func7 = '0;
  logic [2:0]  func3 = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [31:0] imm = '0;
  logic [4:0]  rd_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        regwrite;
  logic [3:0]  alu_op;
  logic        illegal;

  alu_exec_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func7(func7), .func3(func3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .rd_out(rd_out), .regwrite(regwrite), .alu_op(alu_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic [3:0]  op;
    logic        ill;
    int          acc;
    int          lat;
  } exp_t;

  // Reference model: decode by rule, compute with plain arithmetic.
  function automatic exp_t model(input logic [6:0] opc, input logic [6:0] f7,
                                 input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] r2, input logic [31:0] im,
                                 input logic [4:0] rd);
    exp_t e;
    logic [31:0] b;
    int op;
    int sh;
    logic [31:0] ones;
    op = 15;
    b  = 32'h0;
    if (opc == 7'h33) begin
      b = r2;
      if (f7 == 7'h00) op = (f3 == 0) ? 0 : (f3 == 1) ? 2 : (f3 == 2) ? 3 : (f3 == 3) ? 4 :
                            (f3 == 4) ? 5 : (f3 == 5) ? 6 : (f3 == 6) ? 8 : 9;
      else if (f7 == 7'h20 && f3 == 0) op = 1;
      else if (f7 == 7'h20 && f3 == 5) op = 7;
    end else if (opc == 7'h13) begin
      b = im;
      if (f3 == 0) op = 0;
      else if (f3 == 2) op = 3;
      else if (f3 == 3) op = 4;
      else if (f3 == 4) op = 5;
      else if (f3 == 6) op = 8;
      else if (f3 == 7) op = 9;
      else if (f3 == 1 && f7 == 7'h00) op = 2;
      else if (f3 == 5 && f7 == 7'h00) op = 6;
      else if (f3 == 5 && f7 == 7'h20) op = 7;
    end
    sh   = int'(b % 32);
    ones = 32'hFFFF_FFFF;
    e.res = 32'h0;
    case (op)
      0: e.res = a + b;
      1: e.res = a + (~b + 32'h1);
      2: e.res = a << sh;
      3: e.res = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'h1 : 32'h0;
      4: e.res = (a < b) ? 32'h1 : 32'h0;
      5: e.res = a ^ b;
      6: e.res = a >> sh;
      7: e.res = (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0);
      8: e.res = a | b;
      9: e.res = a & b;
      default: e.res = 32'h0;
    endcase
    e.op  = 4'(op);
    e.ill = (op == 15);
    e.rw  = (op != 15) && (rd != 0);
    e.rd  = rd;
    e.acc = 0;
    e.lat = (SERIAL && (op == 2 || op == 6 || op == 7) && sh != 0) ? sh + 1 : 1;
    return e;
  endfunction

  exp_t q[$];
  int   cyc = 0;

  always @(negedge clk) begin
    logic vis;
    logic rdy;
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_result", result, 0);
      chk("rst_rd_out", rd_out, 0);
      chk("rst_regwrite", regwrite, 0);
      chk("rst_alu_op", alu_op, 4'hF);
      chk("rst_illegal", illegal, 0);
    end else begin
      vis = (q.size() > 0) && (cyc >= q[0].acc + q[0].lat);
      rdy = (q.size() == 0) || (vis && out_ready);
      chk("out_valid", out_valid, vis);
      chk("in_ready", in_ready, rdy);
      if (vis && out_valid) begin
        chk("result", result, q[0].res);
        chk("rd_out", rd_out, q[0].rd);
        chk("regwrite", regwrite, q[0].rw);
        chk("alu_op", alu_op, q[0].op);
        chk("illegal", illegal, q[0].ill);
      end
      if (vis && out_ready) void'(q.pop_front());
      if (in_valid && in_ready) begin
        e = model(opcode, func7, func3, rs1_data, rs2_data, imm, rd_in);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic issue(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [4:0] rd);
    bit ok;
    ok = 0;
    opcode = opc; func7 = f7; func3 = f3;
    rs1_data = a; rs2_data = b; imm = im; rd_in = rd;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_lit(input string name, input logic [31:0] r, input logic [3:0] op,
                          input logic rw, input logic ill, input int lat);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) begin seen = 1; break; end
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
    else begin
      chk({name, "_result"}, result, r);
      chk({name, "_alu_op"}, alu_op, op);
      chk({name, "_regwrite"}, regwrite, rw);
      chk({name, "_illegal"}, illegal, ill);
      chk({name, "_latency"}, n, lat);
    end
  endtask

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic [4:0]  rd;
    logic [31:0] r;
    logic [3:0]  op;
    logic        rw;
    logic        ill;
    int          lat_ser;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int cnt;
    tbl[0]  = '{"add_wrap", 7'h33, 7'h00, 3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd5, 32'h0, 4'h0, 1'b1, 1'b0, 1};
    tbl[1]  = '{"srai", 7'h13, 7'h20, 3'd5, 32'h8000_0000, 32'h0, 32'h4, 5'd7, 32'hF800_0000, 4'h7, 1'b1, 1'b0, 5};
    tbl[2]  = '{"ill_f7", 7'h33, 7'h01, 3'd0, 32'h1234, 32'h1, 32'h0, 5'd3, 32'h0, 4'hF, 1'b0, 1'b1, 1};
    tbl[3]  = '{"slt", 7'h33, 7'h00, 3'd2, 32'hFFFF_FFFE, 32'h1, 32'h0, 5'd4, 32'h1, 4'h3, 1'b1, 1'b0, 1};
    tbl[4]  = '{"sltu", 7'h33, 7'h00, 3'd3, 32'hFFFF_FFFE, 32'h1, 32'h0, 5'd4, 32'h0, 4'h4, 1'b1, 1'b0, 1};
    tbl[5]  = '{"slt_rd0", 7'h33, 7'h00, 3'd2, 32'hFFFF_FFFE, 32'h1, 32'h0, 5'd0, 32'h1, 4'h3, 1'b0, 1'b0, 1};
    tbl[6]  = '{"sub", 7'h33, 7'h20, 3'd0, 32'h5, 32'h7, 32'h0, 5'd1, 32'hFFFF_FFFE, 4'h1, 1'b1, 1'b0, 1};
    tbl[7]  = '{"slli31", 7'h13, 7'h00, 3'd1, 32'h1, 32'h0, 32'd31, 5'd2, 32'h8000_0000, 4'h2, 1'b1, 1'b0, 32};
    tbl[8]  = '{"srl", 7'h33, 7'h00, 3'd5, 32'hF000_0000, 32'h24, 32'h0, 5'd9, 32'h0F00_0000, 4'h6, 1'b1, 1'b0, 5};
    tbl[9]  = '{"xori", 7'h13, 7'h55, 3'd4, 32'h0F0F_0F0F, 32'h0, 32'hFFFF_FFFF, 5'd10, 32'hF0F0_F0F0, 4'h5, 1'b1, 1'b0, 1};
    tbl[10] = '{"or", 7'h33, 7'h00, 3'd6, 32'hF0, 32'h0F, 32'h0, 5'd11, 32'hFF, 4'h8, 1'b1, 1'b0, 1};
    tbl[11] = '{"andi", 7'h13, 7'h00, 3'd7, 32'hFF, 32'h0, 32'h3C, 5'd12, 32'h3C, 4'h9, 1'b1, 1'b0, 1};
    tbl[12] = '{"ill_slli", 7'h13, 7'h20, 3'd1, 32'h1, 32'h0, 32'h3, 5'd13, 32'h0, 4'hF, 1'b0, 1'b1, 1};
    tbl[13] = '{"ill_opc", 7'h37, 7'h00, 3'd0, 32'h1, 32'h1, 32'h0, 5'd14, 32'h0, 4'hF, 1'b0, 1'b1, 1};
    tbl[14] = '{"sra_sh0", 7'h33, 7'h20, 3'd5, 32'h8000_0000, 32'h20, 32'h0, 5'd15, 32'h8000_0000, 4'h7, 1'b1, 1'b0, 1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[i]) begin
      issue(tbl[i].opc, tbl[i].f7, tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].im, tbl[i].rd);
      wait_lit(tbl[i].name, tbl[i].r, tbl[i].op, tbl[i].rw, tbl[i].ill, SERIAL ? tbl[i].lat_ser : 1);
      @(posedge clk);
      #1;
    end

    // backpressure: result held while out_ready is low
    out_ready = 1'b0;
    issue(7'h33, 7'h00, 3'd0, 32'h1000, 32'h0234, 32'h0, 5'd6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_result", result, 32'h1234);
      chk("hold_rd_out", rd_out, 5'd6);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      opcode = 7'h33; func7 = 7'h00; func3 = 3'd0;
      rs1_data = 32'(i * 100); rs2_data = 32'(i + 1); rd_in = 5'(i + 16);
      in_valid = 1'b1;
      @(negedge clk);
      if (out_valid) cnt++;
      chk("b2b_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    if (out_valid) cnt++;
    chk("b2b_valid_cycles", cnt, 11);
    repeat (2) @(posedge clk);
    #1;

    // reset while a long shift is in flight
    issue(7'h33, 7'h00, 3'd1, 32'h1, 32'd20, 32'h0, 5'd8);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 0) chk("postrst_in_ready", in_ready, 1);
      if (out_valid) cnt++;
    end
    chk("postrst_no_result", cnt, 0);

    issue(7'h13, 7'h00, 3'd0, 32'h7, 32'h0, 32'hFFFF_FFFF, 5'd31);
    wait_lit("postrst_addi", 32'h6, 4'h0, 1'b1, 1'b0, 1);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
